// File: rtl/game_sequencer.sv
// Game flow controller for the LED-matrix rhythm game: button conditioning plus the
// START / MENU / COUNT / PLAY / FINISH sequence with song selection and control strobes.
module game_sequencer #(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned NUM_SONGS       = 3,
   parameter int unsigned COUNTDOWN_TICKS = 3,
   parameter int unsigned TICK_DIV        = 8,
   parameter int unsigned FINISH_HOLD     = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       red_button,
   input  logic       blue_button,
   input  logic       yellow_button,
   input  logic       song_done,
   output logic [2:0] state,
   output logic [1:0] song_sel,
   output logic [1:0] song_id,
   output logic [2:0] countdown,
   output logic       play_en,
   output logic       song_start,
   output logic       song_abort,
   output logic       score_clr,
   output logic       red_press,
   output logic       blue_press
);

   localparam int unsigned NUM_BTN = 3;
   localparam int unsigned DEB_W   = 4;
   localparam int unsigned TICK_W  = 8;
   localparam int unsigned HOLD_W  = 8;
   localparam int unsigned SEL_W   = 2;
   localparam int unsigned CD_W    = 3;

   // Button indices within the conditioned vectors.
   localparam int unsigned BTN_RED    = 0;
   localparam int unsigned BTN_BLUE   = 1;
   localparam int unsigned BTN_YELLOW = 2;

   typedef enum logic [2:0] {
      ST_START  = 3'd0,
      ST_MENU   = 3'd1,
      ST_COUNT  = 3'd2,
      ST_PLAY   = 3'd3,
      ST_FINISH = 3'd4
   } state_e;

   logic [NUM_BTN-1:0] sync1_q, sync1_d;
   logic [NUM_BTN-1:0] sync2_q, sync2_d;
   logic [NUM_BTN-1:0] deb_q, deb_d;
   logic [NUM_BTN-1:0] deb_prev_q, deb_prev_d;
   logic [NUM_BTN-1:0] press_q, press_d;
   logic [DEB_W-1:0]   cnt_q [NUM_BTN];
   logic [DEB_W-1:0]   cnt_d [NUM_BTN];

   logic               done_q, done_d;
   state_e             state_q, state_d;
   logic [SEL_W-1:0]   sel_q, sel_d;
   logic [SEL_W-1:0]   id_q, id_d;
   logic [CD_W-1:0]    cd_q, cd_d;
   logic [TICK_W-1:0]  tick_q, tick_d;
   logic [HOLD_W-1:0]  hold_q, hold_d;
   logic               play_q, play_d;
   logic               start_q, start_d;
   logic               abort_q, abort_d;
   logic               clr_q, clr_d;

   logic red_p, blue_p, yel_p;

   // Synchronise, debounce and edge-detect all three buttons.
   always_comb begin
      sync1_d    = {yellow_button, blue_button, red_button};
      sync2_d    = sync1_q;
      deb_d      = deb_q;
      deb_prev_d = deb_q;
      press_d    = deb_q & ~deb_prev_q;
      for (int i = 0; i < NUM_BTN; i++) begin
         cnt_d[i] = '0;
         if (sync2_q[i] != deb_q[i]) begin
            if (cnt_q[i] == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
               deb_d[i] = sync2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + DEB_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q    <= '0;
         sync2_q    <= '0;
         deb_q      <= '0;
         deb_prev_q <= '0;
         press_q    <= '0;
         for (int i = 0; i < NUM_BTN; i++) cnt_q[i] <= '0;
      end else begin
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         deb_q      <= deb_d;
         deb_prev_q <= deb_prev_d;
         press_q    <= press_d;
         for (int i = 0; i < NUM_BTN; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   assign red_p  = press_q[BTN_RED];
   assign blue_p = press_q[BTN_BLUE];
   assign yel_p  = press_q[BTN_YELLOW];

   // Next-state and registered-output logic of the game flow.
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      id_d    = id_q;
      cd_d    = cd_q;
      tick_d  = tick_q;
      hold_d  = hold_q;
      start_d = 1'b0;
      abort_d = 1'b0;
      clr_d   = 1'b0;
      done_d  = song_done;

      unique case (state_q)
         ST_START: begin
            if (|press_q) begin
               state_d = ST_MENU;
               sel_d   = SEL_W'(1);
            end
         end
         ST_MENU: begin
            if (yel_p) begin
               state_d = ST_COUNT;
               id_d    = sel_q;
               clr_d   = 1'b1;
               cd_d    = CD_W'(COUNTDOWN_TICKS);
               tick_d  = '0;
            end else if (red_p && !blue_p) begin
               sel_d = (sel_q == SEL_W'(1)) ? SEL_W'(NUM_SONGS) : sel_q - SEL_W'(1);
            end else if (blue_p && !red_p) begin
               sel_d = (sel_q == SEL_W'(NUM_SONGS)) ? SEL_W'(1) : sel_q + SEL_W'(1);
            end
         end
         ST_COUNT: begin
            if (tick_q == TICK_W'(TICK_DIV - 1)) begin
               tick_d = '0;
               if (cd_q == CD_W'(1)) begin
                  state_d = ST_PLAY;
                  cd_d    = '0;
                  start_d = 1'b1;
               end else begin
                  cd_d = cd_q - CD_W'(1);
               end
            end else begin
               tick_d = tick_q + TICK_W'(1);
            end
         end
         ST_PLAY: begin
            if (done_q) begin
               state_d = ST_FINISH;
               hold_d  = '0;
            end else if (yel_p) begin
               state_d = ST_MENU;
               abort_d = 1'b1;
            end
         end
         ST_FINISH: begin
            // Yellow is only honoured once the result screen has been shown long enough.
            if (hold_q != HOLD_W'(FINISH_HOLD)) begin
               hold_d = hold_q + HOLD_W'(1);
            end else if (yel_p) begin
               state_d = ST_MENU;
            end
         end
         default: state_d = ST_START;
      endcase

      play_d = (state_d == ST_PLAY);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done_q  <= 1'b0;
         state_q <= ST_START;
         sel_q   <= '0;
         id_q    <= '0;
         cd_q    <= '0;
         tick_q  <= '0;
         hold_q  <= '0;
         play_q  <= 1'b0;
         start_q <= 1'b0;
         abort_q <= 1'b0;
         clr_q   <= 1'b0;
      end else begin
         done_q  <= done_d;
         state_q <= state_d;
         sel_q   <= sel_d;
         id_q    <= id_d;
         cd_q    <= cd_d;
         tick_q  <= tick_d;
         hold_q  <= hold_d;
         play_q  <= play_d;
         start_q <= start_d;
         abort_q <= abort_d;
         clr_q   <= clr_d;
      end
   end

   assign state      = state_q;
   assign song_sel   = sel_q;
   assign song_id    = id_q;
   assign countdown  = cd_q;
   assign play_en    = play_q;
   assign song_start = start_q;
   assign song_abort = abort_q;
   assign score_clr  = clr_q;
   assign red_press  = press_q[BTN_RED];
   assign blue_press = press_q[BTN_BLUE];

endmodule
